stopwatch_timebase: RTL and testbench

STOPWATCH_TIMEBASE -- requirements
Module: stopwatch_timebase

---
 rtl/stopwatch_timebase.sv | 157 +++++++++++++++
 tb/tb_stopwatch_timebase.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase
//   Stopwatch core: prescaler that turns clk into 0.01 s ticks, an
//   IDLE/RUN/PAUSED control FSM, a BCD time cascade (cs, s, min), and a lap
//   freeze register that holds the display while the time keeps counting.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high
//   start_stop  pulse: IDLE->RUN, RUN->PAUSED, PAUSED->RUN
//   clear       pulse: zero time/prescaler/overflow/lap outside RUN
//   lap         pulse: freeze display (in RUN) or release it (any state)
//   running     high while in RUN
//   lap_active  high while the display is frozen
//   tick        one-cycle pulse per 0.01 s increment
//   overflow    sticky flag, set when time wraps past MAX_MIN:59.99
//   cs_*/s_*/m_* BCD display digits
module stopwatch_timebase #(
    parameter int DIV_COUNT = 1000000,
    parameter int MAX_MIN   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       running,
    output logic       lap_active,
    output logic       tick,
    output logic       overflow,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic [3:0] m_ones,
    output logic [3:0] m_tens
);

    localparam int         PW    = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] LAST = PW'(DIV_COUNT - 1);
    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   presc;
    // digit index: 0 cs ones, 1 cs tens, 2 s ones, 3 s tens, 4 min ones, 5 min tens
    logic [5:0][3:0] time_q, time_next, cap_q, disp;
    logic            wrap, roll;
    logic            do_clear, lap_on, lap_off;

    // Prescaler terminal count in RUN is the 0.01 s increment edge.
    assign wrap = (state == RUN) && (presc == LAST);

    // start_stop outranks clear and lap; clear outranks lap.
    assign do_clear = !start_stop && clear && (state != RUN);
    assign lap_on   = !start_stop && !do_clear && lap && !lap_active && (state == RUN);
    assign lap_off  = !start_stop && !do_clear && lap && lap_active;

    // -------------------------------------------------------------- FSM
    always_comb begin
        state_next = state;
        if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSED;
                PAUSED:  state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (clear && state == PAUSED) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------ BCD cascade
    // All carries ripple combinationally so the whole increment lands on
    // a single edge.
    always_comb begin
        time_next = time_q;
        roll      = 1'b0;
        if (wrap) begin
            if (time_q[0] != 4'd9) time_next[0] = time_q[0] + 4'd1;
            else begin
                time_next[0] = 4'd0;
                if (time_q[1] != 4'd9) time_next[1] = time_q[1] + 4'd1;
                else begin
                    time_next[1] = 4'd0;
                    if (time_q[2] != 4'd9) time_next[2] = time_q[2] + 4'd1;
                    else begin
                        time_next[2] = 4'd0;
                        if (time_q[3] != 4'd5) time_next[3] = time_q[3] + 4'd1;
                        else begin
                            time_next[3] = 4'd0;
                            if (time_q[5] == MAX_T && time_q[4] == MAX_O) begin
                                time_next[4] = 4'd0;
                                time_next[5] = 4'd0;
                                roll         = 1'b1;
                            end else if (time_q[4] != 4'd9) begin
                                time_next[4] = time_q[4] + 4'd1;
                            end else begin
                                time_next[4] = 4'd0;
                                time_next[5] = time_q[5] + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            tick       <= 1'b0;
            overflow   <= 1'b0;
            presc      <= '0;
            time_q     <= '0;
            cap_q      <= '0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            tick    <= wrap;
            if (do_clear) begin
                presc      <= '0;
                time_q     <= '0;
                overflow   <= 1'b0;
                lap_active <= 1'b0;
            end else begin
                if (state == RUN) begin
                    presc  <= wrap ? '0 : presc + PW'(1);
                    time_q <= time_next;
                    if (roll) overflow <= 1'b1;
                end
                if (lap_on) begin
                    lap_active <= 1'b1;
                    cap_q      <= disp;   // what the user sees this cycle
                end else if (lap_off) begin
                    lap_active <= 1'b0;
                end
            end
        end
    end

    // Live time goes straight to the outputs so a new value appears in the
    // same cycle as its tick pulse.
    assign disp    = lap_active ? cap_q : time_q;
    assign cs_ones = disp[0];
    assign cs_tens = disp[1];
    assign s_ones  = disp[2];
    assign s_tens  = disp[3];
    assign m_ones  = disp[4];
    assign m_tens  = disp[5];

endmodule

// File: tb/tb_stopwatch_timebase.sv
module tb_stopwatch_timebase;

    localparam int DIV     = 4;
    localparam int MAX_MIN = 1;
    localparam int WRAP_CS = (MAX_MIN + 1) * 6000;

    logic       clk = 1'b0;
    logic       reset, start_stop, clear, lap;
    logic       running, lap_active, tick, overflow;
    logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;

    stopwatch_timebase #(.DIV_COUNT(DIV), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .running(running), .lap_active(lap_active), .tick(tick), .overflow(overflow),
        .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
        .m_ones(m_ones), .m_tens(m_tens)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        run;
        logic        lapa;
        logic        tck;
        logic        ovf;
        logic [23:0] dig;
    } exp_t;

    typedef struct {
        bit ss, clr, lp;
        bit e_run, e_lap, e_tick, e_ovf;
        int e_time;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural reference: time kept as an integer count of centiseconds
    int m_st, m_presc, m_t, m_cap;
    bit m_lap, m_ovf, m_tick;

    function automatic logic [23:0] to_dig(int t);
        int m, s, c;
        m = t / 6000;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] dut_dig();
        return {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_presc = 0; m_t = 0; m_cap = 0;
        m_lap = 0; m_ovf = 0; m_tick = 0;
    endfunction

    function automatic void model_edge(bit ss, bit clr, bit lp);
        int old_disp;
        old_disp = m_lap ? m_cap : m_t;
        m_tick = 0;
        if (m_st == 1) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_t++;
                m_tick = 1;
                if (m_t == WRAP_CS) begin
                    m_t = 0;
                    m_ovf = 1;
                end
            end else m_presc++;
        end
        if (ss) m_st = (m_st == 1) ? 2 : 1;
        else if (clr && m_st != 1) begin
            m_st = 0; m_t = 0; m_presc = 0; m_ovf = 0; m_lap = 0;
        end else if (lp) begin
            if (m_lap) m_lap = 0;
            else if (m_st == 1) begin
                m_lap = 1;
                m_cap = old_disp;
            end
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.run  = (m_st == 1);
        e.lapa = m_lap;
        e.tck  = m_tick;
        e.ovf  = m_ovf;
        e.dig  = to_dig(m_lap ? m_cap : m_t);
        return e;
    endfunction

    // One clock edge: drive pulses, queue the expectation, compare after the edge.
    task automatic step(input bit ss, input bit clr, input bit lp,
                        input bit use_tbl = 0, input exp_t tbl = '0);
        exp_t e;
        start_stop = ss; clear = clr; lap = lp;
        model_edge(ss, clr, lp);
        sb.push_back(use_tbl ? tbl : model_exp());
        @(posedge clk);
        #1;
        start_stop = 0; clear = 0; lap = 0;
        e = sb.pop_front();
        check("running",    32'(running),    32'(e.run));
        check("lap_active", 32'(lap_active), 32'(e.lapa));
        check("tick",       32'(tick),       32'(e.tck));
        check("overflow",   32'(overflow),   32'(e.ovf));
        check("digits",     32'(dut_dig()),  32'(e.dig));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        #1;
        check("rst_running", 32'(running),    0);
        check("rst_lap",     32'(lap_active), 0);
        check("rst_tick",    32'(tick),       0);
        check("rst_ovf",     32'(overflow),   0);
        check("rst_digits",  32'(dut_dig()),  0);
        start_stop = 1; clear = 1; lap = 1;   // must be ignored during reset
        repeat (2) @(posedge clk);
        #1;
        start_stop = 0; clear = 0; lap = 0;
        check("rst_hold_running", 32'(running), 0);
        @(negedge clk);
        reset = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[16];
    int   ticks, waited;
    bit   seen;

    initial begin
        reset = 0; start_stop = 0; clear = 0; lap = 0;
        model_reset();

        //          ss clr lp  run lap tck ovf time
        vecs[0]  = '{1, 0, 0,  1,  0,  0,  0,  0};
        vecs[1]  = '{0, 0, 0,  1,  0,  0,  0,  0};
        vecs[2]  = '{0, 0, 0,  1,  0,  0,  0,  0};
        vecs[3]  = '{0, 0, 0,  1,  0,  0,  0,  0};
        vecs[4]  = '{0, 0, 0,  1,  0,  1,  0,  1};
        vecs[5]  = '{0, 0, 1,  1,  1,  0,  0,  1};
        vecs[6]  = '{0, 0, 0,  1,  1,  0,  0,  1};
        vecs[7]  = '{0, 0, 0,  1,  1,  0,  0,  1};
        vecs[8]  = '{0, 0, 0,  1,  1,  1,  0,  1};
        vecs[9]  = '{0, 0, 1,  1,  0,  0,  0,  2};
        vecs[10] = '{0, 1, 0,  1,  0,  0,  0,  2};
        vecs[11] = '{1, 1, 0,  0,  0,  0,  0,  2};
        vecs[12] = '{0, 0, 0,  0,  0,  0,  0,  2};
        vecs[13] = '{0, 0, 1,  0,  0,  0,  0,  2};
        vecs[14] = '{0, 1, 0,  0,  0,  0,  0,  0};
        vecs[15] = '{1, 0, 0,  1,  0,  0,  0,  0};

        // ---- table-driven basic control sequence
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.run  = vecs[i].e_run;
            e.lapa = vecs[i].e_lap;
            e.tck  = vecs[i].e_tick;
            e.ovf  = vecs[i].e_ovf;
            e.dig  = to_dig(vecs[i].e_time);
            step(vecs[i].ss, vecs[i].clr, vecs[i].lp, 1, e);
        end

        // ---- 40 cycles of RUN -> 10 ticks, 00:00.10
        do_reset();
        step(1, 0, 0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0);
            if (tick) ticks++;
        end
        check("ticks_in_40", 32'(ticks), 10);
        check("time_0010", 32'(dut_dig()), 32'h000010);
        check("running_0010", 32'(running), 1);

        // ---- carry into seconds, then full wrap with overflow
        for (int i = 0; i < 90 * DIV; i++) step(0, 0, 0);
        check("tick_0100", 32'(tick), 1);
        check("time_0100", 32'(dut_dig()), 32'h000100);
        for (int i = 0; i < (WRAP_CS - 100) * DIV; i++) step(0, 0, 0);
        check("tick_wrap", 32'(tick), 1);
        check("time_wrap", 32'(dut_dig()), 0);
        check("ovf_wrap", 32'(overflow), 1);

        // ---- clear handling
        for (int i = 0; i < 5 * DIV; i++) step(0, 0, 0);
        step(0, 1, 0);
        check("clr_run_time", 32'(dut_dig()), 32'h000005);
        check("clr_run_state", 32'(running), 1);
        step(1, 1, 0);
        check("ssclr_state", 32'(running), 0);
        check("ssclr_time", 32'(dut_dig()), 32'h000005);
        check("ssclr_ovf", 32'(overflow), 1);
        step(0, 1, 0);
        check("clr_pause_time", 32'(dut_dig()), 0);
        check("clr_pause_ovf", 32'(overflow), 0);
        check("clr_pause_state", 32'(running), 0);

        // ---- pause preserves the fractional tick
        step(1, 0, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 0, 0);
            seen = tick;
        end
        check("pause_first_tick", 32'(seen), 1);
        step(0, 0, 0);
        step(1, 0, 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (tick) ticks++;
        end
        check("ticks_paused", 32'(ticks), 0);
        step(1, 0, 0);
        waited = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 0, 0);
            waited++;
            seen = tick;
        end
        check("resume_tick_seen", 32'(seen), 1);
        check("resume_tick_delay", 32'(waited), 2);

        // ---- lap freeze at 00:00.05
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < 5 * DIV; i++) step(0, 0, 0);
        step(0, 0, 1);
        check("lap_set", 32'(lap_active), 1);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0);
            if (tick) ticks++;
            check("lap_hold", 32'(dut_dig()), 32'h000005);
        end
        check("lap_ticks", 32'(ticks), 10);
        step(0, 0, 1);
        check("lap_release", 32'(dut_dig()), 32'h000015);
        check("lap_cleared", 32'(lap_active), 0);

        // ---- asynchronous reset mid-RUN with the display frozen
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        #2;
        reset = 1;
        #1;
        check("arst_running", 32'(running),    0);
        check("arst_lap",     32'(lap_active), 0);
        check("arst_tick",    32'(tick),       0);
        check("arst_ovf",     32'(overflow),   0);
        check("arst_digits",  32'(dut_dig()),  0);
        @(posedge clk);
        #1;
        check("arst_idle", 32'(running), 0);
        @(negedge clk);
        reset = 0;
        model_reset();
        step(0, 0, 0);
        step(1, 0, 0);
        check("post_rst_run", 32'(running), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
